// File: rtl/vx_skid_pkg.sv
// Shared types for vx_skid_buffer: FSM state encoding and perf counter width.
// 2'd3 is not a legal state; the buffer decodes it as EMPTY.
// No logic here; types and constants only.
package vx_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int SKID_PERF_W = 32;

endpackage

// File: rtl/vx_skid_buffer.sv
// Two-entry valid/ready skid buffer; optional stall counter under VX_SKID_BUFFER_PERF_EN.
// Latency: 1 cycle from input transfer to valid_out (0 with PASSTHRU=1).
// Backpressure: ready_in is registered and drops only once both entries hold data.
module vx_skid_buffer
  import vx_skid_pkg::*;
#(
  parameter int DATAW    = 8,
  parameter bit PASSTHRU = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
`ifdef VX_SKID_BUFFER_PERF_EN
  ,
  output logic [SKID_PERF_W-1:0] perf_stalls
`endif
);

  if (PASSTHRU) begin : g_passthru
    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign ready_in  = ready_out;
`ifdef VX_SKID_BUFFER_PERF_EN
    assign perf_stalls = '0;
`endif
  end else begin : g_skid
    skid_state_t      state;
    skid_state_t      st;
    logic [DATAW-1:0] out_q;
    logic [DATAW-1:0] skid_q;

    // Collapse the unused encoding onto EMPTY so outputs stay well defined.
    always_comb begin
      st = EMPTY;
      if (state == BUSY)      st = BUSY;
      else if (state == FULL) st = FULL;
    end

    assign ready_in  = (st != FULL);
    assign valid_out = (st != EMPTY);
    assign data_out  = out_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= EMPTY;
      end else begin
        case (st)
          EMPTY: if (valid_in) state <= BUSY;
          BUSY: begin
            if (valid_in && !ready_out)      state <= FULL;
            else if (!valid_in && ready_out) state <= EMPTY;
          end
          FULL:    if (ready_out) state <= BUSY;
          default: state <= EMPTY;
        endcase
      end
    end

    // Payload registers carry no reset: data_out is only meaningful with valid_out.
    always_ff @(posedge clk) begin
      case (st)
        EMPTY: if (valid_in) out_q <= data_in;
        BUSY: begin
          if (valid_in) begin
            if (ready_out) out_q  <= data_in;
            else           skid_q <= data_in;
          end
        end
        FULL:    if (ready_out) out_q <= skid_q;
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) assert (state == EMPTY || state == BUSY || state == FULL);
    end

`ifdef VX_SKID_BUFFER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                      perf_stalls <= '0;
      else if (valid_in && !ready_in) perf_stalls <= perf_stalls + SKID_PERF_W'(1);
    end
`endif
  end

endmodule

// File: tb/tb_vx_skid_buffer.sv
// Bench for vx_skid_buffer: directed and random traffic against a two-slot queue model.
module tb_vx_skid_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_in;
  logic       valid_out;
  logic [7:0] data_out;
  logic       ready_out;
`ifdef VX_SKID_BUFFER_PERF_EN
  logic [31:0] perf_stalls;
`endif

  vx_skid_buffer #(.DATAW(8), .PASSTHRU(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_out (ready_out)
`ifdef VX_SKID_BUFFER_PERF_EN
    ,
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mq[$];          // words held by the buffer, oldest first
  logic [31:0] exp_stalls = 0;
  bit          no_a5 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the buffer is a 2-deep FIFO whose flags reflect occupancy at the cycle start.
  task automatic check_model();
    logic in_f;
    logic out_f;
    chk("valid_out", valid_out, mq.size() != 0);
    chk("ready_in", ready_in, mq.size() < 2);
    if (mq.size() != 0) chk("data_out", data_out, mq[0]);
    if (no_a5) chk("no_a5", valid_out && data_out == 8'hA5, 1'b0);
`ifdef VX_SKID_BUFFER_PERF_EN
    chk("perf_stalls", perf_stalls, exp_stalls);
    if (valid_in && mq.size() == 2) exp_stalls = exp_stalls + 32'd1;
`endif
    in_f  = valid_in && (mq.size() < 2);
    out_f = ready_out && (mq.size() != 0);
    if (out_f) void'(mq.pop_front());
    if (in_f) mq.push_back(data_in);
  endtask

  task automatic cycle(input logic vin, input logic [7:0] din, input logic rout);
    valid_in  = vin;
    data_in   = din;
    ready_out = rout;
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  // Producer holds each word until accepted; rnd picks random valid/ready, else ready toggles.
  task automatic run_words(input int nw, input bit rnd, input logic [7:0] base);
    int         sent = 0;
    int         cyc  = 0;
    logic       pend = 1'b0;
    logic [7:0] pd   = 8'h00;
    logic       rv;
    logic       acc;
    while (sent < nw && cyc < 8 * nw + 16) begin
      if (!pend && (!rnd || $urandom_range(1, 0) == 1)) begin
        pend = 1'b1;
        pd   = rnd ? 8'($urandom) : base + 8'(sent);
      end
      rv  = rnd ? 1'($urandom_range(1, 0)) : cyc[0];
      acc = pend && (mq.size() < 2);
      cycle(pend, pd, rv);
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("words_sent", sent, nw);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00; ready_out = 1'b0;
    @(posedge clk); #1;
    chk("reset_valid_out", valid_out, 1'b0);
    chk("reset_ready_in", ready_in, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word, then a 16-word stream at full rate
    cycle(1'b1, 8'h3C, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Skid fill, producer stalled on 0x33 while FULL, then drain
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    repeat (3) cycle(1'b1, 8'h33, 1'b0);
    repeat (2) cycle(1'b1, 8'h33, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // ready_out toggling every cycle with a continuously valid producer
    run_words(12, 1'b0, 8'h80);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset while FULL with 0xA5 in the skid slot
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    valid_in = 1'b1; data_in = 8'h77; ready_out = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_ready_in", ready_in, 1'b1);
    mq.delete();
    exp_stalls = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    no_a5 = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    run_words(4, 1'b0, 8'h10);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    no_a5 = 1'b0;

`ifdef VX_SKID_BUFFER_PERF_EN
    reset = 1'b1; #1; reset = 1'b0;
    exp_stalls = 0;
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    repeat (7) cycle(1'b1, 8'h43, 1'b0);
    chk("perf_seven", perf_stalls, 32'd7);
    force dut.perf_stalls = 32'hFFFF_FFFF;
    exp_stalls = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stalls;
    cycle(1'b1, 8'h43, 1'b0);
    chk("perf_wrap", perf_stalls, 32'd0);
    repeat (2) cycle(1'b1, 8'h43, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
`endif

    // Random valid and ready, 1000 words
    run_words(1000, 1'b1, 8'h00);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
